// File: rtl/bfloat_16_div.sv
// rtl/bfloat_16_div.sv - sequential bfloat16 restoring divider (significand/exponent split form)
module bfloat_16_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_sig,
    input  logic [7:0] b_sig,
    input  logic [7:0] a_exp,
    input  logic [7:0] b_exp,
    input  logic       a_s,
    input  logic       b_s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sig,
    output logic [7:0] out_exp,
    output logic       out_s,
    output logic       dz,
    output logic       ovf,
    output logic       unf
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_HOLD} state_t;

    state_t     state_q, state_d;
    logic [8:0] r_q, r_d;
    logic [8:0] q_q, q_d;
    logic [3:0] count_q, count_d;
    logic [7:0] b_sig_q, b_sig_d;
    logic       a_hid_q, a_hid_d;
    logic [7:0] a_exp_q, a_exp_d;
    logic [7:0] b_exp_q, b_exp_d;
    logic       s_q, s_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_sig_q, out_sig_d;
    logic [7:0] out_exp_q, out_exp_d;
    logic       out_s_q, out_s_d;
    logic       dz_q, dz_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;

    logic       ge;
    logic [8:0] rem;
    logic [7:0] norm_sig;
    logic [9:0] e_w;

    // Quotient exponent; the extra -1 compensates the left shift when q[8] is clear.
    assign e_w = {2'b00, a_exp_q} - {2'b00, b_exp_q} + 10'd127 - {9'd0, ~q_q[8]};

    // Next-state, restoring-division step and result normalisation.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        count_d     = count_q;
        b_sig_d     = b_sig_q;
        a_hid_d     = a_hid_q;
        a_exp_d     = a_exp_q;
        b_exp_d     = b_exp_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        out_sig_d   = out_sig_q;
        out_exp_d   = out_exp_q;
        out_s_d     = out_s_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        ge          = 1'b0;
        rem         = r_q;
        norm_sig    = q_q[8] ? q_q[8:1] : q_q[7:0];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    b_sig_d = b_sig;
                    a_hid_d = a_sig[7];
                    a_exp_d = a_exp;
                    b_exp_d = b_exp;
                    s_d     = a_s ^ b_s;
                    r_d     = {1'b0, a_sig};
                    q_d     = 9'd0;
                    count_d = 4'd8;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Quotient bits shift in MSB-first, so q[8] lands on top after 9 steps.
                ge  = (r_q >= {1'b0, b_sig_q});
                rem = ge ? (r_q - {1'b0, b_sig_q}) : r_q;
                q_d = {q_q[7:0], ge};
                r_d = rem << 1;
                if (count_q == 4'd0) begin
                    state_d = S_NORM;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_NORM: begin
                out_valid_d = 1'b1;
                out_s_d     = s_q;
                dz_d        = 1'b0;
                ovf_d       = 1'b0;
                unf_d       = 1'b0;
                if (!b_sig_q[7]) begin
                    dz_d      = 1'b1;
                    out_exp_d = 8'hFF;
                    out_sig_d = 8'h80;
                end else if (!a_hid_q) begin
                    out_exp_d = 8'h00;
                    out_sig_d = 8'h00;
                end else if ($signed(e_w) >= 10'sd255) begin
                    ovf_d     = 1'b1;
                    out_exp_d = 8'hFF;
                    out_sig_d = 8'h80;
                end else if ($signed(e_w) <= 10'sd0) begin
                    unf_d     = 1'b1;
                    out_exp_d = 8'h00;
                    out_sig_d = 8'h00;
                end else begin
                    out_exp_d = e_w[7:0];
                    out_sig_d = norm_sig;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_q         <= 9'd0;
            q_q         <= 9'd0;
            count_q     <= 4'd0;
            b_sig_q     <= 8'd0;
            a_hid_q     <= 1'b0;
            a_exp_q     <= 8'd0;
            b_exp_q     <= 8'd0;
            s_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sig_q   <= 8'd0;
            out_exp_q   <= 8'd0;
            out_s_q     <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            count_q     <= count_d;
            b_sig_q     <= b_sig_d;
            a_hid_q     <= a_hid_d;
            a_exp_q     <= a_exp_d;
            b_exp_q     <= b_exp_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_sig_q   <= out_sig_d;
            out_exp_q   <= out_exp_d;
            out_s_q     <= out_s_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_sig   = out_sig_q;
    assign out_exp   = out_exp_q;
    assign out_s     = out_s_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_bfloat_16_div.sv
// tb/tb_bfloat_16_div.sv - directed self-checking bench for bfloat_16_div
module tb_bfloat_16_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_sig = 8'd0;
    logic [7:0] b_sig = 8'd0;
    logic [7:0] a_exp = 8'd0;
    logic [7:0] b_exp = 8'd0;
    logic       a_s = 1'b0;
    logic       b_s = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sig;
    logic [7:0] out_exp;
    logic       out_s;
    logic       dz;
    logic       ovf;
    logic       unf;

    int n_cmp = 0;
    int n_err = 0;

    bfloat_16_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_s       (a_s),
        .b_s       (b_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_exp   (out_exp),
        .out_s     (out_s),
        .dz        (dz),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands (optionally on the current negedge), accept, scramble inputs, measure latency.
    task automatic issue(input string tag, input logic now,
                         input logic [7:0] as_, input logic [7:0] ae, input logic an,
                         input logic [7:0] bs_, input logic [7:0] be, input logic bn);
        int k;
        if (!now) @(negedge clk);
        chk({tag, ":in_ready"}, {15'd0, in_ready}, 16'd1);
        a_sig = as_; a_exp = ae; a_s = an;
        b_sig = bs_; b_exp = be; b_s = bn;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a_sig = 8'h5A; b_sig = 8'h33; a_exp = 8'h11; b_exp = 8'hEE; a_s = ~an; b_s = bn;
        k = 0;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ":latency"}, k[15:0], 16'd10);
    endtask

    task automatic expect_res(input string tag, input logic [7:0] es, input logic [7:0] ee,
                              input logic esg, input logic edz, input logic eovf, input logic eunf);
        chk({tag, ":out_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, ":out_sig"},   {8'd0, out_sig},    {8'd0, es});
        chk({tag, ":out_exp"},   {8'd0, out_exp},    {8'd0, ee});
        chk({tag, ":out_s"},     {15'd0, out_s},     {15'd0, esg});
        chk({tag, ":flags"},     {13'd0, dz, ovf, unf}, {13'd0, edz, eovf, eunf});
    endtask

    task automatic finish_hs(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":hs_out_valid"}, {15'd0, out_valid}, 16'd0);
        chk({tag, ":hs_in_ready"},  {15'd0, in_ready},  16'd1);
    endtask

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst:in_ready",  {15'd0, in_ready},  16'd1);
        chk("rst:out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst:out_data",  {out_sig, out_exp}, 16'd0);
        chk("rst:out_flags", {12'd0, out_s, dz, ovf, unf}, 16'd0);
        rst_n = 1'b1;

        // 1.5 / 1.0 with out_ready already high: handshake on the edge after out_valid rises
        out_ready = 1'b1;
        issue("t1", 1'b0, 8'hC0, 8'd127, 1'b0, 8'h80, 8'd127, 1'b0);
        expect_res("t1", 8'hC0, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1:hs_out_valid", {15'd0, out_valid}, 16'd0);
        chk("t1:hs_in_ready",  {15'd0, in_ready},  16'd1);

        // 1.0 / 1.5 negative: q[8]=0 path
        issue("t2", 1'b0, 8'h80, 8'd127, 1'b1, 8'hC0, 8'd127, 1'b0);
        expect_res("t2", 8'hAA, 8'd126, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_hs("t2");

        issue("ovf", 1'b0, 8'h80, 8'd254, 1'b0, 8'h80, 8'd1, 1'b0);
        expect_res("ovf", 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_hs("ovf");

        issue("unf", 1'b0, 8'h80, 8'd1, 1'b0, 8'h80, 8'd200, 1'b0);
        expect_res("unf", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_hs("unf");

        // divide by zero wins over zero dividend
        issue("dz", 1'b0, 8'h00, 8'd100, 1'b1, 8'h00, 8'd50, 1'b0);
        expect_res("dz", 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        finish_hs("dz");

        issue("zero", 1'b0, 8'h00, 8'd130, 1'b0, 8'h80, 8'd127, 1'b1);
        expect_res("zero", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_hs("zero");

        // e = 254, largest normal exponent
        issue("emax", 1'b0, 8'hC0, 8'd254, 1'b0, 8'h80, 8'd127, 1'b0);
        expect_res("emax", 8'hC0, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_hs("emax");

        // e = 1 - 127 + 127 - 1 = 0 -> underflow
        issue("ezero", 1'b0, 8'h80, 8'd1, 1'b0, 8'hC0, 8'd127, 1'b0);
        expect_res("ezero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_hs("ezero");

        // backpressure: outputs hold, in_valid ignored
        issue("bp", 1'b0, 8'h80, 8'd127, 1'b1, 8'hC0, 8'd127, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a_sig = 8'hFF; b_sig = 8'h81; a_exp = 8'd3; b_exp = 8'd9;
            chk("bp:in_ready", {15'd0, in_ready}, 16'd0);
            expect_res("bp", 8'hAA, 8'd126, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp:hs_out_valid", {15'd0, out_valid}, 16'd0);
        chk("bp:hs_in_ready",  {15'd0, in_ready},  16'd1);
        issue("bp_next", 1'b1, 8'hE0, 8'd129, 1'b0, 8'h80, 8'd127, 1'b0);
        expect_res("bp_next", 8'hE0, 8'd129, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_hs("bp_next");

        // async reset in the middle of DIV clears held result registers
        @(negedge clk);
        a_sig = 8'hC0; a_exp = 8'd127; b_sig = 8'h80; b_exp = 8'd127;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst:in_ready",  {15'd0, in_ready},  16'd1);
        chk("arst:out_valid", {15'd0, out_valid}, 16'd0);
        chk("arst:out_data",  {out_sig, out_exp}, 16'd0);
        chk("arst:out_flags", {12'd0, out_s, dz, ovf, unf}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk("arst:no_spurious", {15'd0, seen}, 16'd0);

        issue("fresh", 1'b0, 8'hA0, 8'd130, 1'b1, 8'h80, 8'd128, 1'b1);
        expect_res("fresh", 8'hA0, 8'd129, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_hs("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
